// File: rtl/gpu_pkg.sv
// Shared TXBL dimensions, command/state encodings and write payload
// for the text-layer GPU blocks.
package gpu_pkg;

    localparam int unsigned TXBL_COLS   = 32;
    localparam int unsigned TXBL_ADDR_W = 10;
    localparam int unsigned TXBL_DATA_W = 8;
    localparam int unsigned TXBL_ROW_W  = 5;
    localparam int unsigned TXBL_COL_W  = 5;

    typedef enum logic {
        TXBL_CLEAR  = 1'b0,
        TXBL_SCROLL = 1'b1
    } txbl_op_e;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCROLL_COPY,
        SCROLL_FILL,
        FINISH
    } txbl_state_e;

    typedef struct packed {
        logic [TXBL_ADDR_W-1:0] addr;
        logic [TXBL_DATA_W-1:0] data;
    } txbl_wr_t;

endpackage

// File: rtl/txbl_port_arb.sv
// Single TXBL write port mux: CPU always wins, the engine only writes
// (and may advance) on cycles the CPU leaves free.
module txbl_port_arb
    import gpu_pkg::*;
(
    input  logic                   rst,
    input  logic                   cpu_we,
    input  logic [TXBL_ADDR_W-1:0] cpu_addr,
    input  logic [TXBL_DATA_W-1:0] cpu_data,
    input  logic                   eng_req,
    input  logic [TXBL_ADDR_W-1:0] eng_addr,
    input  logic [TXBL_DATA_W-1:0] eng_data,
    output logic                   we_c,
    output logic [TXBL_ADDR_W-1:0] addr_c,
    output logic [TXBL_DATA_W-1:0] data_c,
    output logic                   eng_go_c
);

    txbl_wr_t sel_c;

    always_comb begin
        we_c     = 1'b0;
        eng_go_c = 1'b0;
        sel_c    = '{addr: cpu_addr, data: cpu_data};
        if (!rst) begin
            if (cpu_we) begin
                we_c = 1'b1;
            end else if (eng_req) begin
                we_c     = 1'b1;
                eng_go_c = 1'b1;
                sel_c    = '{addr: eng_addr, data: eng_data};
            end
        end
    end

    assign addr_c = sel_c.addr;
    assign data_c = sel_c.data;

endmodule

// File: rtl/text_scroll_ctrl.sv
// Clear / scroll-up engine for the 32-column text table, one tile per
// free write-port cycle, optionally restricted to vertical blank.
module text_scroll_ctrl
    import gpu_pkg::*;
#(
    parameter int unsigned ROWS        = 30,
    parameter int unsigned VBLANK_ONLY = 1
) (
    input  logic                   gpu_clk,
    input  logic                   rst,
    input  logic                   vblank,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [TXBL_DATA_W-1:0] cmd_fill,
    output logic                   busy,
    output logic                   done,
    input  logic                   cpu_we,
    input  logic [TXBL_ADDR_W-1:0] cpu_addr,
    input  logic [TXBL_DATA_W-1:0] cpu_data,
    output logic                   txbl_we,
    output logic [TXBL_ADDR_W-1:0] txbl_addr,
    output logic [TXBL_DATA_W-1:0] txbl_wdata,
    output logic [TXBL_ADDR_W-1:0] txbl_rd_addr,
    input  logic [TXBL_DATA_W-1:0] txbl_rd_data
);

    localparam logic [TXBL_ROW_W-1:0] LAST_ROW      = TXBL_ROW_W'(ROWS - 1);
    localparam logic [TXBL_ROW_W-1:0] LAST_COPY_ROW = TXBL_ROW_W'(ROWS - 2);
    localparam logic [TXBL_COL_W-1:0] LAST_COL      = TXBL_COL_W'(TXBL_COLS - 1);
    localparam logic                  VB_GATE       = (VBLANK_ONLY != 0);

    txbl_state_e             state, state_d;
    logic [TXBL_ROW_W-1:0]   row, row_d;
    logic [TXBL_COL_W-1:0]   col, col_d;
    logic [TXBL_DATA_W-1:0]  fill, fill_d;
    logic                    done_d;

    logic                    active_c;
    logic                    eng_req_c;
    logic                    eng_go_c;
    logic [TXBL_DATA_W-1:0]  eng_data_c;
    logic [TXBL_ROW_W-1:0]   src_row_c;

    assign active_c   = (state == CLEAR) || (state == SCROLL_COPY) || (state == SCROLL_FILL);
    assign eng_req_c  = active_c && (vblank || !VB_GATE);
    assign eng_data_c = (state == SCROLL_COPY) ? txbl_rd_data : fill;
    assign src_row_c  = row + TXBL_ROW_W'(1);

    // Copy reads the row below the one being written.
    assign txbl_rd_addr = (state == SCROLL_COPY) ? {src_row_c, col} : '0;

    txbl_port_arb u_arb (
        .rst      (rst),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .eng_req  (eng_req_c),
        .eng_addr ({row, col}),
        .eng_data (eng_data_c),
        .we_c     (txbl_we),
        .addr_c   (txbl_addr),
        .data_c   (txbl_wdata),
        .eng_go_c (eng_go_c)
    );

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            fill      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_d;
            row       <= row_d;
            col       <= col_d;
            fill      <= fill_d;
            done      <= done_d;
            busy      <= (state_d != IDLE);
            cmd_ready <= (state_d == IDLE);
        end
    end

    // Counters only move on cycles the engine actually owns the port.
    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        fill_d  = fill;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    fill_d = cmd_fill;
                    row_d  = '0;
                    col_d  = '0;
                    if (txbl_op_e'(cmd_op) == TXBL_SCROLL) begin
                        state_d = (ROWS == 1) ? SCROLL_FILL : SCROLL_COPY;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (eng_go_c) begin
                    col_d = col + TXBL_COL_W'(1);
                    if (col == LAST_COL) begin
                        row_d = row + TXBL_ROW_W'(1);
                        if (row == LAST_ROW) state_d = FINISH;
                    end
                end
            end
            SCROLL_COPY: begin
                if (eng_go_c) begin
                    col_d = col + TXBL_COL_W'(1);
                    if (col == LAST_COL) begin
                        if (row == LAST_COPY_ROW) begin
                            row_d   = LAST_ROW;
                            col_d   = '0;
                            state_d = SCROLL_FILL;
                        end else begin
                            row_d = row + TXBL_ROW_W'(1);
                        end
                    end
                end
            end
            SCROLL_FILL: begin
                if (eng_go_c) begin
                    col_d = col + TXBL_COL_W'(1);
                    if (col == LAST_COL) state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_scroll_ctrl.sv
// Bench for text_scroll_ctrl: TXBL storage model, per-cycle reference model
// of the command engine, and directed clear/scroll/priority/vblank/reset cases.
module tb_text_scroll_ctrl;
    import gpu_pkg::*;

    localparam int unsigned ROWS = 30;
    localparam int NT = ROWS * 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vblank, cmd_valid, cmd_valid0, cmd_op, cpu_we;
    logic [7:0] cmd_fill, cpu_data;
    logic [9:0] cpu_addr;

    logic       ready1, busy1, done1, we1;
    logic [9:0] addr1, rd_addr1;
    logic [7:0] wdata1, rd_data1;
    logic       ready0, busy0, done0, we0;
    logic [9:0] addr0, rd_addr0;
    logic [7:0] wdata0, rd_data0;

    text_scroll_ctrl #(.ROWS(ROWS), .VBLANK_ONLY(1)) u1 (
        .gpu_clk(clk), .rst(rst), .vblank(vblank),
        .cmd_valid(cmd_valid), .cmd_ready(ready1), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
        .busy(busy1), .done(done1),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .txbl_we(we1), .txbl_addr(addr1), .txbl_wdata(wdata1),
        .txbl_rd_addr(rd_addr1), .txbl_rd_data(rd_data1)
    );

    text_scroll_ctrl #(.ROWS(ROWS), .VBLANK_ONLY(0)) u0 (
        .gpu_clk(clk), .rst(rst), .vblank(1'b0),
        .cmd_valid(cmd_valid0), .cmd_ready(ready0), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
        .busy(busy0), .done(done0),
        .cpu_we(1'b0), .cpu_addr(10'd0), .cpu_data(8'd0),
        .txbl_we(we0), .txbl_addr(addr0), .txbl_wdata(wdata0),
        .txbl_rd_addr(rd_addr0), .txbl_rd_data(rd_data0)
    );

    // TXBL storage for each instance, with a preload hook.
    logic [7:0] mem1 [1024];
    logic [7:0] mem0 [1024];
    logic [7:0] save0 [1024];
    logic [7:0] ref_mem [1024];
    bit pl_go1 = 0, pl_go0 = 0, ref_sync = 0;

    always @(posedge clk) begin
        if (pl_go1) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 8'(i);
        end else if (we1) begin
            mem1[addr1] <= wdata1;
        end
    end
    assign rd_data1 = mem1[rd_addr1];

    always @(posedge clk) begin
        if (pl_go0) begin
            for (int i = 0; i < 1024; i++) begin
                automatic logic [7:0] r = 8'($urandom);
                mem0[i]  <= r;
                save0[i] <= r;
            end
        end else if (we0) begin
            mem0[addr0] <= wdata0;
        end
    end
    assign rd_data0 = mem0[rd_addr0];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for u1: phase 0 idle, 1 working on flat tile index m_k,
    // 2 finishing, 3 idle with the done pulse showing.
    int         m_phase = 0;
    int         m_k = 0;
    logic       m_scroll = 1'b0;
    logic [7:0] m_fill = 8'h00;
    bit         m_on = 0;
    logic       e_req, e_we;
    logic [9:0] e_addr;
    logic [7:0] e_data, e_eng;

    always @(negedge clk) begin
        if (ref_sync) for (int i = 0; i < 1024; i++) ref_mem[i] = mem1[i];
        if (rst) begin
            chk("we_during_rst", 32'(we1), 32'd0);
            m_phase = 0;
            m_k     = 0;
            m_on    = 1;
        end else if (m_on) begin
            e_req  = (m_phase == 1) && vblank;
            e_eng  = (m_scroll && m_k < NT - 32) ? ref_mem[m_k + 32] : m_fill;
            e_we   = cpu_we || e_req;
            e_addr = cpu_we ? cpu_addr : 10'(m_k);
            e_data = cpu_we ? cpu_data : e_eng;
            chk("busy", 32'(busy1), 32'(m_phase == 1 || m_phase == 2));
            chk("cmd_ready", 32'(ready1), 32'(m_phase == 0 || m_phase == 3));
            chk("done", 32'(done1), 32'(m_phase == 3));
            chk("txbl_we", 32'(we1), 32'(e_we));
            if (e_we) begin
                chk("txbl_addr", 32'(addr1), 32'(e_addr));
                chk("txbl_wdata", 32'(wdata1), 32'(e_data));
            end
            if (m_phase == 1 && m_scroll && m_k < NT - 32)
                chk("txbl_rd_addr", 32'(rd_addr1), 32'(m_k + 32));
            if (cpu_we) ref_mem[cpu_addr] = cpu_data;
            if ((m_phase == 0 || m_phase == 3) && cmd_valid) begin
                m_phase  = 1;
                m_k      = 0;
                m_scroll = cmd_op;
                m_fill   = cmd_fill;
            end else if (m_phase == 3) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (e_req && !cpu_we) begin
                    ref_mem[m_k] = e_eng;
                    m_k++;
                    if (m_k == NT) m_phase = 2;
                end
            end else if (m_phase == 2) begin
                m_phase = 3;
            end
        end
    end

    int eng_wr_cnt = 0, lowvb_writes = 0;
    always @(negedge clk) begin
        if (we1 && !cpu_we && !rst) begin
            eng_wr_cnt++;
            if (!vblank) lowvb_writes++;
        end
    end

    // Issue one command at posedge+1 and measure accept-to-done cycles.
    task automatic run_cmd(input bit u0sel, input logic op, input logic [7:0] fill,
                           input int limit, output int lat, output int busy_n);
        cmd_op   = op;
        cmd_fill = fill;
        if (u0sel) cmd_valid0 = 1'b1; else cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_valid0 = 1'b0;
        lat    = 1;
        busy_n = 0;
        forever begin
            @(negedge clk);
            if (u0sel ? busy0 : busy1) busy_n++;
            if (u0sel ? done0 : done1) break;
            if (lat >= limit) begin
                chk("done_timeout", 32'(lat), 32'(limit + 1));
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic mem_vs_model(input string name);
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (mem1[i] !== ref_mem[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic preload1();
        pl_go1 = 1;
        @(posedge clk); #1;
        pl_go1   = 0;
        ref_sync = 1;
        @(negedge clk); #1;
        ref_sync = 0;
        @(posedge clk); #1;
    endtask

    int lat, bn, bad, n;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; vblank = 0; cmd_valid = 0; cmd_valid0 = 0; cmd_op = 0; cmd_fill = 0;
        cpu_we = 1; cpu_addr = 10'd5; cpu_data = 8'h77;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_blocks_cpu_we", 32'(we1), 32'd0);
        @(posedge clk); #1;
        rst = 0; cpu_we = 0;
        @(negedge clk);
        chk("reset_ready0", 32'(ready0), 32'd1);
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_done0", 32'(done0), 32'd0);
        chk("reset_ready1", 32'(ready1), 32'd1);
        @(posedge clk); #1;

        // Clear on the free-running instance, no CPU traffic
        pl_go0 = 1;
        @(posedge clk); #1;
        pl_go0 = 0;
        run_cmd(1'b1, 1'b0, 8'h20, 3000, lat, bn);
        chk("clear_done_latency", 32'(lat), 32'd962);
        chk("clear_busy_cycles", 32'(bn), 32'd961);
        bad = 0;
        for (int i = 0; i < NT; i++) if (mem0[i] !== 8'h20) bad++;
        chk("clear_body", 32'(bad), 32'd0);
        bad = 0;
        for (int i = NT; i < 1024; i++) if (mem0[i] !== save0[i]) bad++;
        chk("clear_tail_untouched", 32'(bad), 32'd0);

        // Scroll up on identity content
        vblank = 1;
        preload1();
        run_cmd(1'b0, 1'b1, 8'h00, 3000, lat, bn);
        chk("scroll_done_latency", 32'(lat), 32'd962);
        chk("scroll_busy_cycles", 32'(bn), 32'd961);
        chk("scroll_tile0", 32'(mem1[0]), 32'h20);
        chk("scroll_r28c3", 32'(mem1[28*32+3]), 32'hA3);
        chk("scroll_r29c7", 32'(mem1[29*32+7]), 32'h00);
        chk("scroll_tile960", 32'(mem1[960]), 32'hC0);
        bad = 0;
        for (int r = 0; r < 29; r++)
            for (int c = 0; c < 32; c++)
                if (mem1[r*32+c] !== 8'((r+1)*32+c)) bad++;
        chk("scroll_body", 32'(bad), 32'd0);
        mem_vs_model("scroll_mem_vs_model");

        // CPU priority during a scroll
        preload1();
        fork
            run_cmd(1'b0, 1'b1, 8'h5A, 3000, lat, bn);
            begin
                repeat (100) begin @(posedge clk); #1; end
                cpu_we = 1; cpu_addr = 10'h3FF; cpu_data = 8'hAA;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("cpu_pri_we", 32'(we1), 32'd1);
                    chk("cpu_pri_addr", 32'(addr1), 32'h3FF);
                    chk("cpu_pri_data", 32'(wdata1), 32'hAA);
                    @(posedge clk); #1;
                end
                cpu_we = 0;
            end
        join
        chk("cpu_pri_latency", 32'(lat), 32'd967);
        chk("cpu_pri_tile3ff", 32'(mem1[10'h3FF]), 32'hAA);
        chk("cpu_pri_r29", 32'(mem1[29*32]), 32'h5A);
        mem_vs_model("cpu_pri_mem_vs_model");

        // Vblank-gated clear: 100 of every 500 cycles
        eng_wr_cnt = 0;
        lowvb_writes = 0;
        fork
            run_cmd(1'b0, 1'b0, 8'h55, 6000, lat, bn);
            for (int r = 0; r < 4600; r++) begin
                vblank = ((r % 500) < 100);
                @(posedge clk); #1;
            end
        join
        chk("vb_done_latency", 32'(lat), 32'd4562);
        chk("vb_engine_writes", 32'(eng_wr_cnt), 32'd960);
        chk("vb_writes_outside_vblank", 32'(lowvb_writes), 32'd0);
        mem_vs_model("vb_mem_vs_model");

        // Busy rejection, then reset at engine write 400
        vblank = 1;
        cmd_op = 0; cmd_fill = 8'h11; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_fill = 8'h22;
        n = 0; lat = 1;
        forever begin
            @(negedge clk);
            if (!ready1) n++;
            if (done1) break;
            if (lat >= 3000) begin chk("hold_timeout", 32'(lat), 32'd3001); break; end
            @(posedge clk); #1;
            lat++;
        end
        chk("ready_low_cycles", 32'(n), 32'd961);
        @(posedge clk); #1;
        cmd_valid = 0;
        @(negedge clk);
        chk("reaccept_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        lat = 0;
        while (!(m_phase == 1 && m_k == 400) && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("reach_write_400", 32'(m_k), 32'd400);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_we", 32'(we1), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_busy", 32'(busy1), 32'd0);
            chk("rst_mid_no_done", 32'(done1), 32'd0);
            @(posedge clk); #1;
        end
        bad = 0;
        for (int i = 0; i < 400; i++) if (mem1[i] !== 8'h22) bad++;
        chk("rst_written_tiles", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 400; i < NT; i++) if (mem1[i] !== 8'h11) bad++;
        chk("rst_later_tiles", 32'(bad), 32'd0);
        mem_vs_model("rst_mem_vs_model");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
